// File: rtl/inst_rom_if.sv
// i_instbus: CPU instruction-fetch bus between the fetch stage and the instruction ROM.
interface i_instbus;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] data;
  modport master (output ce, addr, input data);
  modport slave (input ce, addr, output data);
endinterface

// File: rtl/inst_rom.sv
// inst_rom: instruction ROM zero-filled after reset, written by a loader port, read combinationally by fetch.
module inst_rom #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  i_instbus.slave               rom,
  input  logic                  load_valid,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  output logic                  load_ready,
  output logic                  stallreq,
  output logic                  misaligned,
  output logic [ADDR_WIDTH:0]   load_count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic {CLEAR, READY} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [ADDR_WIDTH:0]   r_load_count;
  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_fidx, w_lidx;
  logic                  w_ready, w_load, w_aligned, w_unused;
  assign w_fidx     = rom.addr[ADDR_WIDTH+1:2];
  assign w_lidx     = load_addr[ADDR_WIDTH+1:2];
  assign w_aligned  = rom.addr[1:0] == 2'b00;
  assign w_ready    = r_state == READY && rst;
  assign w_load     = load_valid && w_ready;
  assign w_unused   = ^{rom.addr[31:ADDR_WIDTH+2], load_addr[31:ADDR_WIDTH+2], load_addr[1:0]};
  assign load_ready = w_ready;
  assign stallreq   = r_state == CLEAR;
  assign misaligned = rom.ce && !w_aligned;
  assign load_count = r_load_count;
  assign rom.data   = (rom.ce && w_ready && w_aligned) ? r_mem[w_fidx] : 32'h0;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == CLEAR && r_clr_ptr == '1) ? READY : w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= CLEAR_ON_RESET ? CLEAR : READY;
      r_clr_ptr    <= '0;
      r_load_count <= '0;
    end else begin
      r_state      <= w_next;
      r_clr_ptr    <= r_state == CLEAR ? r_clr_ptr + 1'b1 : '0;
      r_load_count <= (w_load && r_load_count != MAX_CNT) ? r_load_count + 1'b1 : r_load_count;
    end
  end
  // No reset here so contents survive reset when clearing is disabled.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) r_mem[r_clr_ptr] <= 32'h0;
    else if (w_load) r_mem[w_lidx] <= load_data;
  end
endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: randomized and directed checks of inst_rom (ADDR_WIDTH=4) against a behavioural model.
module tb_inst_rom;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_ready, stallreq, misaligned;
  logic [31:0] load_addr, load_data;
  logic [4:0]  load_count;
  int          errors = 0;
  int          checks = 0;
  int          n;
  int          m_clr, m_cnt;
  logic [31:0] m_mem [16];
  logic [31:0] ra;
  i_instbus rom();
  inst_rom #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .rom(rom), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .stallreq(stallreq),
    .misaligned(misaligned), .load_count(load_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stallreq) break;
      cnt++;
    end
  endtask
  // Model: a countdown of clear cycles, then a plain word array written by accepted loads.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clr <= 16;
      m_cnt <= 0;
    end else if (m_clr > 0) begin
      m_clr <= m_clr - 1;
      if (m_clr == 1) for (int i = 0; i < 16; i++) m_mem[i] <= 32'h0;
    end else if (load_valid) begin
      m_mem[load_addr[5:2]] <= load_data;
      m_cnt <= m_cnt < 16 ? m_cnt + 1 : 16;
    end
  end
  always @(negedge clk) begin
    chk("m_stall", stallreq, 32'(m_clr != 0));
    chk("m_ready", load_ready, 32'(rst && m_clr == 0));
    chk("m_count", 32'(load_count), 32'(m_cnt));
    chk("m_mis", misaligned, 32'(rom.ce && rom.addr[1:0] != 2'b00));
    chk("m_data", rom.data,
        (rom.ce && rst && m_clr == 0 && rom.addr[1:0] == 2'b00) ? m_mem[rom.addr[5:2]] : 32'h0);
  end
  initial begin
    rst = 1'b1; rom.ce = 1'b0; rom.addr = '0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    #1 rst = 1'b0;
    rom.ce = 1'b1; rom.addr = 32'h4;
    repeat (3) @(negedge clk);
    chk("rst_stall", stallreq, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_count", 32'(load_count), 0);
    chk("rst_data", rom.data, 0);
    step(); rst = 1'b1; load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h3C011234;
    wait_ready(n);
    chk("clear_cycles", n, 16);
    chk("ready_rise", load_ready, 1);
    chk("no_count_in_clear", 32'(load_count), 0);
    chk("zero_fetch", rom.data, 0);
    step(); load_addr = 32'h4; load_data = 32'h34210001;
    step(); load_valid = 1'b0; rom.addr = 32'h4;
    @(negedge clk);
    chk("fetch4", rom.data, 32'h34210001);
    chk("count2", 32'(load_count), 2);
    step(); rom.addr = 32'h6;
    @(negedge clk);
    chk("mis_data", rom.data, 0);
    chk("mis_flag", misaligned, 1);
    step(); rom.ce = 1'b0; rom.addr = 32'h0;
    @(negedge clk);
    chk("nce_data", rom.data, 0);
    chk("nce_mis", misaligned, 0);
    step(); rom.ce = 1'b1; load_valid = 1'b1; load_addr = 32'h40; load_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("rbw_old", rom.data, 32'h3C011234);
    step(); load_valid = 1'b0;
    @(negedge clk);
    chk("wrap_new", rom.data, 32'hDEADBEEF);
    chk("count3", 32'(load_count), 3);
    for (int i = 0; i < 16; i++) begin
      step(); load_valid = 1'b1;
      load_addr = (32'(i) << 2) | (32'(i) << 6) | 32'(i & 3);
      load_data = 32'h10000000 + 32'(i);
    end
    step(); load_valid = 1'b0; rom.addr = 32'h1C;
    @(negedge clk);
    chk("fill_word7", rom.data, 32'h10000007);
    chk("count_sat", 32'(load_count), 16);
    repeat (300) begin
      step();
      rom.ce = $urandom_range(0, 3) != 0;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rom.addr = ra;
      load_valid = $urandom_range(0, 1) == 1;
      load_addr = $urandom;
      load_data = $urandom;
    end
    step(); load_valid = 1'b0; rst = 1'b0;
    step(); rst = 1'b1; load_valid = 1'b1;
    repeat (5) step();
    chk("midclear_stall", stallreq, 1);
    rst = 1'b0;
    step(); rst = 1'b1;
    wait_ready(n);
    chk("restart_cycles", n, 16);
    chk("restart_count", 32'(load_count), 0);
    step(); load_valid = 1'b0;
    @(negedge clk);
    chk("first_accept", 32'(load_count), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, word-index width; ROM depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter: CLEAR_ON_RESET, default 1, when 1 the memory is zero-filled after reset before fetches are served.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  reset_status_t  reset, asynchronous and active-low (asserted = low).
REQ-005 Port: rom  i_instbus.slave  (ce 1, addr 32, data 32)  responder end of the CPU instruction-fetch bus; ce/addr in, data out.
REQ-006 Port: load_valid  input  1  loader offers a word.
REQ-007 Port: load_addr  input  32  byte address of loader word.
REQ-008 Port: load_data  input  32  loader word.
REQ-009 Port: load_ready  output  1  loader word accepted this cycle when load_valid and load_ready are both high.
REQ-010 Port: stallreq  output  1  ROM not yet able to serve fetches; feeds the pipeline stall controller.
REQ-011 Port: misaligned  output  1  current fetch address has addr[1:0] != 0.
REQ-012 Port: load_count  output  ADDR_WIDTH+1  number of words accepted since reset, saturating.

Function
REQ-013 The FSM SHALL have states CLEAR, READY; reset enters CLEAR when CLEAR_ON_RESET=1, else READY.
REQ-014 CLEAR: a clear pointer starting at 0 writes 0 to one word per cycle; after writing index 2**ADDR_WIDTH-1 the FSM SHALL enter READY on the next edge (exactly 2**ADDR_WIDTH cycles in CLEAR).
REQ-015 stallreq SHALL be 1 in CLEAR and 0 in READY; load_ready SHALL be 0 in CLEAR and 1 in READY.
REQ-016 Word index = addr[ADDR_WIDTH+1:2] for both fetch and load; addr bits above ADDR_WIDTH+1 SHALL be ignored (address aliases/wraps).
REQ-017 Fetch read is combinational: in READY with rom.ce=1 and addr[1:0]=0, rom.data = mem[index] in the same cycle.
REQ-018 rom.data SHALL be 32'h0 (NOP) when rom.ce=0, when in CLEAR, or when addr[1:0]!=0.
REQ-019 misaligned = rom.ce & (addr[1:0]!=0), combinational; it SHALL NOT affect FSM state.
REQ-020 Load: on an edge with load_valid & load_ready, mem[load index] <= load_data; load_addr[1:0] SHALL be ignored.
REQ-021 Simultaneous fetch and load to the same index: fetch returns the old word that cycle, the new word from the next cycle (read-before-write).
REQ-022 load_count SHALL increment by 1 per accepted load and saturate at 2**ADDR_WIDTH; repeat writes to one index each count.
REQ-023 Back-to-back loads SHALL be accepted every cycle with no bubble.
REQ-024 load_valid high during CLEAR SHALL be ignored (not written, not counted); the loader holds the word until load_ready.

Reset
REQ-025 While rst is low: FSM = CLEAR (or READY if CLEAR_ON_RESET=0), clear pointer = 0, load_count = 0, load_ready = 0, stallreq = 1 (0 if CLEAR_ON_RESET=0), rom.data = 0.
REQ-026 Reset asserted mid-CLEAR or mid-load SHALL abort immediately and restart clearing from index 0 after release; memory contents are not guaranteed except as rewritten.
REQ-027 With CLEAR_ON_RESET=0, memory contents SHALL survive reset.

Verification
REQ-028 Reset release, ADDR_WIDTH=4 -> stallreq=1 for exactly 16 cycles, then 0; load_ready rises with stallreq falling; fetch of any address returns 0.
REQ-029 Load 0x3C011234 at 0x0, 0x34210001 at 0x4 on consecutive cycles -> both accepted, load_count=2; fetch ce=1 addr=0x4 returns 0x34210001 same cycle.
REQ-030 Fetch ce=1 addr=0x6 -> data=0, misaligned=1; ce=0 addr=0x0 -> data=0, misaligned=0.
REQ-031 ADDR_WIDTH=4: load 0xDEADBEEF at 0x40 -> fetch at 0x0 returns 0xDEADBEEF (wrap); same-cycle fetch of 0x0 returns the previous word.
REQ-032 load_valid held high from reset release -> no write or count during CLEAR; first accept on first READY cycle.
REQ-033 rst pulsed low after 5 CLEAR cycles -> stallreq stays 1, clear restarts at 0, READY reached 2**ADDR_WIDTH cycles after release; load_count=0.
